fetch_decode_queue: RTL and testbench

- Small in-order FIFO between the fetch stage (PC + BTB lookup) and the decode stage.
- Buffers fetched instructions together with their PC and BTB prediction.
- Presents the head entry to decode, with opcode/funct fields pre-split for the control unit.
- Decouples fetch from decode stalls; a single-cycle flush discards wrong-path instructions after a branch/jump redirect.

---
 rtl/fetch_decode_queue_pkg.sv | 24 ++
 rtl/fetch_decode_queue_if.sv | 38 +++
 rtl/fetch_decode_queue_storage.sv | 25 ++
 rtl/fetch_decode_queue.sv | 110 +++++++++++
 tb/tb_fetch_decode_queue.sv | 188 ++++++++++++++++++
 5 files changed

// File: rtl/fetch_decode_queue_pkg.sv
// Shared definitions for the fetch/decode instruction queue: defaults, the
// fetch-entry record and the instruction field positions used by decode.
package fetch_decode_queue_pkg;

    localparam int          FDQ_DEPTH = 4;
    localparam int          FDQ_XLEN  = 32;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    // Field positions within a 32-bit instruction word
    localparam int OP_LSB  = 0;
    localparam int OP_MSB  = 6;
    localparam int FN3_LSB = 12;
    localparam int FN3_MSB = 14;
    localparam int FN7_LSB = 25;
    localparam int FN7_MSB = 31;

    typedef struct packed {
        logic [31:0]         instr;
        logic [FDQ_XLEN-1:0] pc;
        logic                pred_taken;
        logic [FDQ_XLEN-1:0] pred_target;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_decode_queue_if.sv
// Handshake bundle between fetch, the queue and decode; master is the
// fetch/decode side, slave is the queue itself.
interface fetch_decode_queue_if #(
    parameter int XLEN = 32,
    parameter int CW   = 3
);
    logic            flush;
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     in_instr;
    logic [XLEN-1:0] in_pc;
    logic            in_pred_taken;
    logic [XLEN-1:0] in_pred_target;
    logic            out_valid;
    logic            out_ready;
    logic [31:0]     out_instr;
    logic [6:0]      out_op;
    logic [2:0]      out_fn3;
    logic [6:0]      out_fn7;
    logic [XLEN-1:0] out_pc;
    logic            out_pred_taken;
    logic [XLEN-1:0] out_pred_target;
    logic [CW-1:0]   count;
    logic            full;
    logic            empty;

    modport master (
        output flush, in_valid, in_instr, in_pc, in_pred_taken, in_pred_target, out_ready,
        input  in_ready, out_valid, out_instr, out_op, out_fn3, out_fn7, out_pc,
               out_pred_taken, out_pred_target, count, full, empty
    );

    modport slave (
        input  flush, in_valid, in_instr, in_pc, in_pred_taken, in_pred_target, out_ready,
        output in_ready, out_valid, out_instr, out_op, out_fn3, out_fn7, out_pc,
               out_pred_taken, out_pred_target, count, full, empty
    );
endinterface

// File: rtl/fetch_decode_queue_storage.sv
// Entry storage for the queue: one write port, one asynchronous read port,
// deliberately not reset (validity is tracked by the pointers/count).
module fdq_storage #(
    parameter int DEPTH = 4,
    parameter int W     = 97,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic [AW-1:0] raddr,
    output logic [W-1:0]  rdata
);
    logic [W-1:0] mem_q [DEPTH];

    // Write port
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];
endmodule

// File: rtl/fetch_decode_queue.sv
// In-order queue between fetch and decode. Head entry is shown combinationally,
// bubbled to a NOP when empty; flush discards everything in one cycle.
module fetch_decode_queue
    import fetch_decode_queue_pkg::*;
#(
    parameter int          DEPTH     = FDQ_DEPTH,
    parameter int          XLEN      = FDQ_XLEN,
    parameter logic [31:0] NOP_INSTR = fetch_decode_queue_pkg::NOP_INSTR
) (
    input logic                 clk,
    input logic                 rst_n,
    fetch_decode_queue_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int EW = 32 + 1 + 2 * XLEN;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] CNT_ONE = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [AW-1:0] PTR_ONE = {{(AW-1){1'b0}}, 1'b1};

    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          full_s, empty_s, push_s, pop_s;
    logic [EW-1:0] wdata_s, rdata_s;

    assign full_s  = (count_q == DEPTH_C);
    assign empty_s = (count_q == {CW{1'b0}});
    // Acceptance looks only at registered fullness, never at out_ready
    assign push_s  = bus.in_valid & ~full_s & ~bus.flush;
    assign pop_s   = bus.out_ready & ~empty_s & ~bus.flush;
    assign wdata_s = {bus.in_instr, bus.in_pc, bus.in_pred_taken, bus.in_pred_target};

    fdq_storage #(.DEPTH(DEPTH), .W(EW), .AW(AW)) u_storage (
        .clk   (clk),
        .we    (push_s),
        .waddr (wr_ptr_q),
        .wdata (wdata_s),
        .raddr (rd_ptr_q),
        .rdata (rdata_s)
    );

    // Pointer and occupancy next state; flush wins over push and pop
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (bus.flush) begin
            wr_ptr_d = {AW{1'b0}};
            rd_ptr_d = {AW{1'b0}};
            count_d  = {CW{1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_d = wr_ptr_q + PTR_ONE;
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (pop_s) begin
                rd_ptr_d = rd_ptr_q + PTR_ONE;
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            case ({push_s, pop_s})
                2'b10:   count_d = count_q + CNT_ONE;
                2'b01:   count_d = count_q - CNT_ONE;
                default: count_d = count_q;
            endcase
        end
    end

    // Pointer and occupancy registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= {AW{1'b0}};
            rd_ptr_q <= {AW{1'b0}};
            count_q  <= {CW{1'b0}};
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Head view: stored entry when occupied, harmless ADDI bubble otherwise
    always_comb begin
        bus.out_instr       = NOP_INSTR;
        bus.out_pc          = {XLEN{1'b0}};
        bus.out_pred_taken  = 1'b0;
        bus.out_pred_target = {XLEN{1'b0}};
        if (empty_s) begin
            bus.out_instr       = NOP_INSTR;
            bus.out_pc          = {XLEN{1'b0}};
            bus.out_pred_taken  = 1'b0;
            bus.out_pred_target = {XLEN{1'b0}};
        end else begin
            bus.out_instr       = rdata_s[EW-1 -: 32];
            bus.out_pc          = rdata_s[2*XLEN -: XLEN];
            bus.out_pred_taken  = rdata_s[XLEN];
            bus.out_pred_target = rdata_s[XLEN-1:0];
        end
    end

    assign bus.out_op    = bus.out_instr[OP_MSB:OP_LSB];
    assign bus.out_fn3   = bus.out_instr[FN3_MSB:FN3_LSB];
    assign bus.out_fn7   = bus.out_instr[FN7_MSB:FN7_LSB];
    assign bus.out_valid = ~empty_s;
    assign bus.in_ready  = ~full_s;
    assign bus.full      = full_s;
    assign bus.empty     = empty_s;
    assign bus.count     = count_q;
endmodule

// File: tb/tb_fetch_decode_queue.sv
// Directed self-checking bench for fetch_decode_queue (DEPTH=4, XLEN=32).
module tb_fetch_decode_queue;
    logic clk;
    logic rst_n;
    int   checks_cnt;
    int   errors_cnt;

    fetch_decode_queue_if #(.XLEN(32), .CW(3)) bus ();

    fetch_decode_queue #(.DEPTH(4), .XLEN(32), .NOP_INSTR(32'h0000_0013)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Free-running clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard time limit so the run always ends
    initial begin
        #100000;
        $display("FAIL timeout reached before summary");
        $fatal(1, "time limit");
    end

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks_cnt++;
        if (got !== exp) begin
            errors_cnt++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic v, input logic [31:0] instr, input logic [31:0] pc);
        bus.in_valid       = v;
        bus.in_instr       = instr;
        bus.in_pc          = pc;
        bus.in_pred_taken  = pc[2];
        bus.in_pred_target = pc + 32'h0000_0100;
    endtask

    // Invariants that must hold whenever outputs are sampled
    task automatic check_inv(input string tag);
        check_val({tag, "_rdy"}, {63'd0, bus.in_ready}, {63'd0, ~bus.full});
        check_val({tag, "_vld"}, {63'd0, bus.out_valid}, {63'd0, ~bus.empty});
    endtask

    initial begin
        checks_cnt    = 0;
        errors_cnt    = 0;
        rst_n         = 1'b0;
        bus.flush     = 1'b0;
        bus.out_ready = 1'b0;
        set_in(1'b0, 32'h0000_0000, 32'h0000_0000);
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // Reset / idle
        check_val("rst_valid", {63'd0, bus.out_valid}, 64'd0);
        check_val("rst_instr", {32'd0, bus.out_instr}, 64'h13);
        check_val("rst_op",    {57'd0, bus.out_op}, 64'h13);
        check_val("rst_count", {61'd0, bus.count}, 64'd0);
        check_val("rst_ready", {63'd0, bus.in_ready}, 64'd1);
        check_val("rst_full",  {63'd0, bus.full}, 64'd0);
        check_val("rst_pc",    {32'd0, bus.out_pc}, 64'd0);

        // Single push, one-cycle latency, no bypass
        set_in(1'b1, 32'h0050_0093, 32'h0000_0000);
        #1;
        check_val("nobypass_valid", {63'd0, bus.out_valid}, 64'd0);
        tick();
        set_in(1'b0, 32'h0000_0000, 32'h0000_0000);
        check_val("push1_valid", {63'd0, bus.out_valid}, 64'd1);
        check_val("push1_instr", {32'd0, bus.out_instr}, 64'h0050_0093);
        check_val("push1_fn3",   {61'd0, bus.out_fn3}, 64'd0);
        check_val("push1_op",    {57'd0, bus.out_op}, 64'h13);
        check_val("push1_imm",   {57'd0, bus.out_fn7}, 64'd0);
        check_val("push1_count", {61'd0, bus.count}, 64'd1);
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        check_val("pop1_count", {61'd0, bus.count}, 64'd0);
        check_val("pop1_instr", {32'd0, bus.out_instr}, 64'h13);

        // Fill to full, fifth push ignored, then drain in order
        for (int i = 0; i < 4; i++) begin
            set_in(1'b1, 32'h0000_0093 | (32'(i) << 20), 32'(i * 4));
            tick();
        end
        check_val("fill_full",  {63'd0, bus.full}, 64'd1);
        check_val("fill_ready", {63'd0, bus.in_ready}, 64'd0);
        check_val("fill_count", {61'd0, bus.count}, 64'd4);
        check_inv("fill");
        set_in(1'b1, 32'hDEAD_0093, 32'h0000_0010);
        tick();
        check_val("fifth_count", {61'd0, bus.count}, 64'd4);
        set_in(1'b0, 32'h0000_0000, 32'h0000_0000);
        bus.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check_val($sformatf("drain%0d_pc", i), {32'd0, bus.out_pc}, 64'(i * 4));
            check_val($sformatf("drain%0d_instr", i), {32'd0, bus.out_instr},
                      {32'd0, 32'h0000_0093 | (32'(i) << 20)});
            check_val($sformatf("drain%0d_taken", i), {63'd0, bus.out_pred_taken}, 64'(i % 2));
            tick();
        end
        bus.out_ready = 1'b0;
        check_val("drain_empty", {63'd0, bus.empty}, 64'd1);
        check_val("drain_count", {61'd0, bus.count}, 64'd0);
        check_val("drain_pc",    {32'd0, bus.out_pc}, 64'd0);
        check_inv("drain");

        // Full plus pop plus in_valid: pop only
        for (int i = 0; i < 4; i++) begin
            set_in(1'b1, 32'h0000_0113, 32'h0000_0020 + 32'(i * 4));
            tick();
        end
        set_in(1'b1, 32'h0000_0113, 32'h0000_0099);
        bus.out_ready = 1'b1;
        tick();
        check_val("fullpop_count", {61'd0, bus.count}, 64'd3);
        check_val("fullpop_pc",    {32'd0, bus.out_pc}, 64'h24);

        // Flush with 3 entries, concurrent push and pop
        set_in(1'b1, 32'h0000_0213, 32'h0000_0077);
        bus.flush = 1'b1;
        #1;
        check_val("flushcyc_valid", {63'd0, bus.out_valid}, 64'd1);
        tick();
        bus.flush     = 1'b0;
        bus.out_ready = 1'b0;
        set_in(1'b0, 32'h0000_0000, 32'h0000_0000);
        check_val("flush_count", {61'd0, bus.count}, 64'd0);
        check_val("flush_valid", {63'd0, bus.out_valid}, 64'd0);
        set_in(1'b1, 32'h0000_0313, 32'h0000_0040);
        tick();
        set_in(1'b1, 32'h0000_0313, 32'h0000_0044);
        check_val("postflush_pc",    {32'd0, bus.out_pc}, 64'h40);
        check_val("postflush_count", {61'd0, bus.count}, 64'd1);
        tick();

        // Steady state: push and pop each cycle at count 2, pointers wrap
        bus.out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            set_in(1'b1, 32'h0000_0313, 32'h0000_0048 + 32'(i * 4));
            #1;
            check_val($sformatf("steady%0d_pc", i), {32'd0, bus.out_pc}, 64'h40 + 64'(i * 4));
            tick();
            check_val($sformatf("steady%0d_count", i), {61'd0, bus.count}, 64'd2);
        end
        bus.out_ready = 1'b0;
        set_in(1'b1, 32'h0000_0313, 32'h0000_0070);
        tick();
        set_in(1'b0, 32'h0000_0000, 32'h0000_0000);
        check_val("pre_rst_count", {61'd0, bus.count}, 64'd3);
        check_val("pre_rst_pc",    {32'd0, bus.out_pc}, 64'h68);

        // Asynchronous reset mid-cycle with 3 entries
        #2;
        rst_n = 1'b0;
        #1;
        check_val("arst_count", {61'd0, bus.count}, 64'd0);
        check_val("arst_valid", {63'd0, bus.out_valid}, 64'd0);
        tick();
        rst_n = 1'b1;
        set_in(1'b1, 32'h0000_0413, 32'h0000_0080);
        #1;
        check_val("rel_valid0", {63'd0, bus.out_valid}, 64'd0);
        tick();
        set_in(1'b0, 32'h0000_0000, 32'h0000_0000);
        check_val("rel_valid1", {63'd0, bus.out_valid}, 64'd1);
        check_val("rel_pc",     {32'd0, bus.out_pc}, 64'h80);
        check_val("rel_target", {32'd0, bus.out_pred_target}, 64'h180);
        check_inv("end");

        $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
        $finish;
    end
endmodule
